// File: rtl/sub_pipe32.sv
// Two-stage pipelined 32-bit subtractor (a + ~b + 1) with valid/ready on both sides.
// Define SUB_PIPE32_OVF_EN to add the signed-overflow output `ovf`.
module sub_pipe32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        borrow
`ifdef SUB_PIPE32_OVF_EN
  ,
  output logic        ovf
`endif
);

  // 16-bit add as four 4-bit lookahead groups; group carries ripple, result is {cout, sum}
  function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin);
    logic [15:0] g, p, s;
    logic [4:0]  gc;
    logic [3:0]  gv, pv;
    logic        grp_g, grp_p, c;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gv    = g[4*k +: 4];
      pv    = p[4*k +: 4];
      grp_g = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1]) | (pv[3] & pv[2] & pv[1] & gv[0]);
      grp_p = &pv;
      c     = gc[k];
      for (int j = 0; j < 4; j++) begin
        s[4*k+j] = pv[j] ^ c;
        c        = gv[j] | (pv[j] & c);
      end
      gc[k+1] = grp_g | (grp_p & gc[k]);
    end
    return {gc[4], s};
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_lo_q, s1_lo_d;
  logic        s1_c16_q, s1_c16_d;
  logic [15:0] s1_ahi_q, s1_ahi_d;
  logic [15:0] s1_nbhi_q, s1_nbhi_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] diff_q, diff_d;
  logic        borrow_q, borrow_d;
`ifdef SUB_PIPE32_OVF_EN
  logic        s1_a31_q, s1_a31_d;
  logic        s1_b31_q, s1_b31_d;
  logic        ovf_q, ovf_d;
`endif

  logic        s2_free, s1_adv, s1_load;
  logic [16:0] lo_sum, hi_sum;

  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    s1_load  = in_valid && in_ready;
    lo_sum   = cla16(a[15:0], ~b[15:0], 1'b1);
    hi_sum   = cla16(s1_ahi_q, s1_nbhi_q, s1_c16_q);

    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c16_d   = s1_c16_q;
    s1_ahi_d   = s1_ahi_q;
    s1_nbhi_d  = s1_nbhi_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
`ifdef SUB_PIPE32_OVF_EN
    s1_a31_d   = s1_a31_q;
    s1_b31_d   = s1_b31_q;
    ovf_d      = ovf_q;
`endif

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_lo_d    = lo_sum[15:0];
      s1_c16_d   = lo_sum[16];
      s1_ahi_d   = a[31:16];
      s1_nbhi_d  = ~b[31:16];
`ifdef SUB_PIPE32_OVF_EN
      s1_a31_d   = a[31];
      s1_b31_d   = b[31];
`endif
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Output registers only change when a new result arrives, so they hold under backpressure
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      diff_d     = {hi_sum[15:0], s1_lo_q};
      borrow_d   = ~hi_sum[16];
`ifdef SUB_PIPE32_OVF_EN
      ovf_d      = (s1_a31_q != s1_b31_q) && (hi_sum[15] != s1_a31_q);
`endif
    end else if (s2_free) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c16_q   <= 1'b0;
      s1_ahi_q   <= '0;
      s1_nbhi_q  <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
`ifdef SUB_PIPE32_OVF_EN
      s1_a31_q   <= 1'b0;
      s1_b31_q   <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c16_q   <= s1_c16_d;
      s1_ahi_q   <= s1_ahi_d;
      s1_nbhi_q  <= s1_nbhi_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
`ifdef SUB_PIPE32_OVF_EN
      s1_a31_q   <= s1_a31_d;
      s1_b31_q   <= s1_b31_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SUB_PIPE32_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
